enc_cmd_sequencer: RTL
======================

Name: enc_cmd_sequencer

Overview:
- Controller in front of enc_driver, the ENC28J60 SPI write engine.
- After reset, waits for the chip's power-on time, then walks a fixed init ROM of register writes. Each entry is issued as one enc_driver transaction.
- Inserts ECON1 bank-select commands automatically.
- After init, accepts runtime write commands from a single user port and applies the same bank handling.

Parameters:
- POR_WAIT_CYCLES, 50000: clk cycles to wait after reset before the first command (1 ms at 50 MHz).
- GAP_CYCLES, 4: idle cycles between end_flag and the next run_req.
- ROM_DEPTH, 8: number of init ROM entries.
- TIMEOUT_CYCLES, 1023: end_flag watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- drv_run_req  out  1  to enc_driver run_req.
- drv_end_flag  in  1  from enc_driver end_flag (one-cycle pulse).
- drv_opcode  out  3  to enc_driver opcode.
- drv_addr  out  5  to enc_driver write_addr.
- drv_data  out  8  to enc_driver write_data.
- usr_valid  in  1  user command valid.
- usr_ready  out  1  user command accepted this cycle.
- usr_opcode  in  3  user opcode.
- usr_addr  in  5  user address.
- usr_data  in  8  user data.
- usr_bank  in  2  user register bank.
- init_done  out  1  high once the ROM is complete; stays high until rst.
- busy  out  1  high whenever the sequencer is not in IDLE.
- err  out  1  sticky driver-timeout flag (tied 0 without the optional feature).

Behaviour:
- Reset values: drv_run_req=0, drv_opcode=0, drv_addr=0, drv_data=0, usr_ready=0, init_done=0, busy=1, err=0. Also: rom_idx=0, cur_bank_valid=0, state=POR_WAIT.
- States: POR_WAIT, FETCH, BANK_CLR, BANK_SET, ISSUE, WAIT_END, GAP, IDLE.
- POR_WAIT: count POR_WAIT_CYCLES, then go to FETCH.
- FETCH, source selection:
  - If init_done=0, load the pending command from ROM[rom_idx].
  - Otherwise come from IDLE with the latched user command.
- FETCH, bank decision:
  - A bank switch is needed when (addr < 5'h1B) and (cur_bank_valid=0 or bank != cur_bank).
  - If needed, go to BANK_CLR; else go to ISSUE.
- BANK_CLR: issue BFC addr 5'h1F data 8'h03.
- BANK_SET: skipped when the target bank is 0. Otherwise issue BFS addr 5'h1F data {6'b0,bank}.
- Bank tracking: after the last bank command completes, set cur_bank=bank and cur_bank_valid=1.
- Common registers (addr 0x1B-0x1F) never trigger a bank switch.
- Transaction protocol, identical for bank and payload commands:
  - Cycle 0: drv_opcode, drv_addr and drv_data take their values, and drv_run_req=1.
  - Cycle 1: drv_run_req=0.
  - drv_opcode, drv_addr and drv_data stay stable until drv_end_flag is seen in WAIT_END.
  - Then GAP for GAP_CYCLES cycles.
- After a payload command completes:
  - During init: rom_idx increments. When rom_idx reaches ROM_DEPTH-1 and that entry completes, init_done=1 and the state goes to IDLE. Otherwise go to FETCH.
  - User command: go to IDLE.
- IDLE user handshake:
  - usr_ready=1 only in IDLE with init_done=1.
  - A command is accepted when usr_valid and usr_ready are both high. Its fields are latched that cycle, and the next state is FETCH.
  - usr_ready is low in every other state.
- drv_end_flag is ignored outside WAIT_END.
- Opcode SRC (3'b111) is not supported on the user port. It is passed through unchanged; its behaviour is undefined.
- rst mid-transaction: all state is reset and POR_WAIT restarts. POR_WAIT_CYCLES is far longer than any driver transaction, so a stale end_flag falls in POR_WAIT and is ignored.
- Counters: POR and GAP counters are sized with $clog2 of their parameter. rom_idx wraps only through reset.

Optional Feature:
- Macro: ENC_SEQ_TIMEOUT_EN.
- Enabled: a counter runs in WAIT_END. If it reaches TIMEOUT_CYCLES without drv_end_flag:
  - err is set (sticky until rst);
  - the command is abandoned and the state goes to GAP;
  - the sequencer then continues (the ROM advances, or it returns to IDLE);
  - cur_bank_valid is cleared.
- Disabled: no counter; WAIT_END waits indefinitely; err is constant 0.

Decomposition:
- Package enc_pkg:
  - opcode constants OP_RCR/RBM/WCR/WBM/BFS/BFC/SRC;
  - ADDR_ECON1=5'h1F, ADDR_COMMON_BASE=5'h1B;
  - typedef struct packed enc_cmd_t {bank[1:0], opcode[2:0], addr[4:0], data[7:0]};
  - state enum.
- Sub-module enc_init_rom: combinational idx -> enc_cmd_t, with this content:
  - 0: b0 WCR 08 00
  - 1: b0 WCR 09 00
  - 2: b0 WCR 0A FF
  - 3: b0 WCR 0B 0F
  - 4: b2 WCR 00 0D
  - 5: b2 WCR 02 32
  - 6: b2 WCR 04 12
  - 7: b0 BFS 1F 04

Test Plan:
- Reset, POR_WAIT_CYCLES=10, driver model returns end_flag 20 cycles after run_req -> first run_req at cycle 10 is BFC/1F/03 (bank 0, so no BFS). Next command is WCR/08/00.
- Full init -> exactly 11 transactions in ROM order, with BFC 1F 03 + BFS 1F 02 before entry 4, and no bank commands before entry 7. init_done=1 after the 11th end_flag + GAP.
- After init, user cmd bank 2, WCR 06 12 -> no bank commands, single transaction. usr_ready=0 from the accept cycle until return to IDLE.
- User cmd bank 3, WCR 01 AA -> BFC 1F 03, BFS 1F 03, WCR 01 AA, each with a one-cycle run_req pulse and payload held stable until its end_flag.
- Spurious end_flag in IDLE, plus rst asserted during WAIT_END of entry 2 -> no state change; init restarts from entry 0 with BFC.
- With ENC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50, driver never answers entry 0 -> err=1 at cycle 50 of WAIT_END. The sequencer proceeds to entry 1 and re-issues bank select.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the ENC28J60 command sequencer: SPI opcodes,
// control-register addresses, the command record and the FSM encoding.
package enc_pkg;

  // ENC28J60 SPI instruction opcodes (upper three bits of the command byte)
  localparam logic [2:0] OP_RCR = 3'b000;
  localparam logic [2:0] OP_RBM = 3'b001;
  localparam logic [2:0] OP_WCR = 3'b010;
  localparam logic [2:0] OP_WBM = 3'b011;
  localparam logic [2:0] OP_BFS = 3'b100;
  localparam logic [2:0] OP_BFC = 3'b101;
  localparam logic [2:0] OP_SRC = 3'b111;

  // ECON1 holds BSEL[1:0]; 0x1B..0x1F are visible from every bank
  localparam logic [4:0] ADDR_ECON1       = 5'h1F;
  localparam logic [4:0] ADDR_COMMON_BASE = 5'h1B;
  localparam logic [7:0] ECON1_BSEL_MASK  = 8'h03;

  typedef struct packed {
    logic [1:0] bank;
    logic [2:0] opcode;
    logic [4:0] addr;
    logic [7:0] data;
  } enc_cmd_t;

  typedef enum logic [2:0] {
    ST_POR_WAIT,
    ST_FETCH,
    ST_BANK_CLR,
    ST_BANK_SET,
    ST_ISSUE,
    ST_WAIT_END,
    ST_GAP,
    ST_IDLE
  } seq_state_t;

  // What the transaction currently in flight is, so GAP knows where to go
  typedef enum logic [1:0] {
    K_CLR,
    K_SET,
    K_PAY
  } xfer_kind_t;

  // Banked register and the selected bank is unknown or different
  function automatic logic needs_bank_sel(input enc_cmd_t c, input logic valid,
                                          input logic [1:0] cur);
    return (c.addr < ADDR_COMMON_BASE) && (!valid || (c.bank != cur));
  endfunction

endpackage

// File: rtl/enc_init_rom.sv
// Fixed power-up register-write table for the ENC28J60. Purely
// combinational: index in, command record out.
module enc_init_rom
  import enc_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] i_idx,
  output enc_cmd_t         o_cmd
);

  // Table lookup; unused indices read as an all-zero command
  always_comb begin
    o_cmd = '0;
    case (int'(i_idx))
      0: o_cmd = {2'd0, OP_WCR, 5'h08, 8'h00};
      1: o_cmd = {2'd0, OP_WCR, 5'h09, 8'h00};
      2: o_cmd = {2'd0, OP_WCR, 5'h0A, 8'hFF};
      3: o_cmd = {2'd0, OP_WCR, 5'h0B, 8'h0F};
      4: o_cmd = {2'd2, OP_WCR, 5'h00, 8'h0D};
      5: o_cmd = {2'd2, OP_WCR, 5'h02, 8'h32};
      6: o_cmd = {2'd2, OP_WCR, 5'h04, 8'h12};
      7: o_cmd = {2'd0, OP_BFS, 5'h1F, 8'h04};
      default: o_cmd = '0;
    endcase
  end

endmodule

// File: rtl/enc_cmd_sequencer.sv
// Command sequencer in front of enc_driver. Waits out the chip power-on
// time, replays the init ROM, then serves user write commands. ECON1
// bank-select writes (BFC then optional BFS) are inserted whenever a banked
// register is addressed and the tracked bank does not match.
// Optional build macro ENC_SEQ_TIMEOUT_EN adds an end_flag watchdog that
// abandons a stuck transaction and raises the sticky err flag.
module enc_cmd_sequencer
  import enc_pkg::*;
#(
  parameter int POR_WAIT_CYCLES = 50000,
  parameter int GAP_CYCLES      = 4,
  parameter int ROM_DEPTH       = 8
`ifdef ENC_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic       drv_run_req,
  input  logic       drv_end_flag,
  output logic [2:0] drv_opcode,
  output logic [4:0] drv_addr,
  output logic [7:0] drv_data,
  input  logic       usr_valid,
  output logic       usr_ready,
  input  logic [2:0] usr_opcode,
  input  logic [4:0] usr_addr,
  input  logic [7:0] usr_data,
  input  logic [1:0] usr_bank,
  output logic       init_done,
  output logic       busy,
  output logic       err
);

  localparam int POR_W = (POR_WAIT_CYCLES > 1) ? $clog2(POR_WAIT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int IDX_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] ROM_LAST = IDX_W'(ROM_DEPTH - 1);

  seq_state_t       r_state, w_next;
  xfer_kind_t       r_kind;
  logic [POR_W-1:0] r_por_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [IDX_W-1:0] r_rom_idx;
  enc_cmd_t         r_cmd;
  logic [1:0]       r_cur_bank;
  logic             r_cur_bank_valid;
  logic             r_init_done;
  logic             r_run_req;
  logic [2:0]       r_opcode;
  logic [4:0]       r_addr;
  logic [7:0]       r_data;

  enc_cmd_t w_rom_cmd, w_src, w_issue_cmd;
  logic     w_need_bank, w_por_done, w_gap_done, w_usr_accept, w_timeout;
  logic     w_usr_ready, w_busy;

  enc_init_rom #(.IDX_W(IDX_W)) u_rom (
    .i_idx (r_rom_idx),
    .o_cmd (w_rom_cmd)
  );

  // During init the ROM feeds FETCH; afterwards the latched user command does
  assign w_src       = r_init_done ? r_cmd : w_rom_cmd;
  assign w_issue_cmd = (r_state == ST_FETCH) ? w_src : r_cmd;
  assign w_need_bank = needs_bank_sel(w_src, r_cur_bank_valid, r_cur_bank);
  assign w_por_done  = (r_por_cnt == POR_W'(POR_WAIT_CYCLES - 1));
  assign w_gap_done  = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign w_usr_accept = usr_valid && w_usr_ready;

`ifdef ENC_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_timeout = (r_state == ST_WAIT_END) && !drv_end_flag &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign err = r_err;

  // Watchdog: counts cycles spent in WAIT_END, sets sticky err on expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == ST_WAIT_END && !drv_end_flag && !w_timeout) ?
                  r_to_cnt + 1'b1 : '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state decode plus the state-derived status outputs
  always_comb begin
    w_next      = r_state;
    w_usr_ready = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_POR_WAIT: if (w_por_done) w_next = ST_FETCH;
      ST_FETCH:    w_next = w_need_bank ? ST_BANK_CLR : ST_ISSUE;
      ST_BANK_CLR,
      ST_BANK_SET,
      ST_ISSUE:    w_next = ST_WAIT_END;
      ST_WAIT_END: if (drv_end_flag || w_timeout) w_next = ST_GAP;
      ST_GAP: begin
        if (w_gap_done) begin
          case (r_kind)
            K_CLR:   w_next = (r_cmd.bank == 2'd0) ? ST_ISSUE : ST_BANK_SET;
            K_SET:   w_next = ST_ISSUE;
            default: w_next = (r_init_done || r_rom_idx == ROM_LAST) ?
                              ST_IDLE : ST_FETCH;
          endcase
        end
      end
      ST_IDLE: begin
        w_busy      = 1'b0;
        w_usr_ready = r_init_done;
        if (usr_valid && r_init_done) w_next = ST_FETCH;
      end
      default: w_next = ST_POR_WAIT;
    endcase
  end

  // State, counters, driver interface registers and bank/ROM bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_POR_WAIT;
      r_kind           <= K_PAY;
      r_por_cnt        <= '0;
      r_gap_cnt        <= '0;
      r_rom_idx        <= '0;
      r_cmd            <= '0;
      r_cur_bank       <= 2'd0;
      r_cur_bank_valid <= 1'b0;
      r_init_done      <= 1'b0;
      r_run_req        <= 1'b0;
      r_opcode         <= 3'd0;
      r_addr           <= 5'd0;
      r_data           <= 8'd0;
    end else begin
      r_state   <= w_next;
      r_por_cnt <= (r_state == ST_POR_WAIT && !w_por_done) ? r_por_cnt + 1'b1 : '0;
      r_gap_cnt <= (r_state == ST_GAP && !w_gap_done) ? r_gap_cnt + 1'b1 : '0;

      // Load the driver fields on entry to an issue state; run_req lasts
      // exactly that one cycle because every issue state leads to WAIT_END
      r_run_req <= 1'b0;
      case (w_next)
        ST_BANK_CLR: begin
          r_run_req <= 1'b1;
          r_opcode  <= OP_BFC;
          r_addr    <= ADDR_ECON1;
          r_data    <= ECON1_BSEL_MASK;
          r_kind    <= K_CLR;
        end
        ST_BANK_SET: begin
          r_run_req <= 1'b1;
          r_opcode  <= OP_BFS;
          r_addr    <= ADDR_ECON1;
          r_data    <= {6'b0, r_cmd.bank};
          r_kind    <= K_SET;
        end
        ST_ISSUE: begin
          r_run_req <= 1'b1;
          r_opcode  <= w_issue_cmd.opcode;
          r_addr    <= w_issue_cmd.addr;
          r_data    <= w_issue_cmd.data;
          r_kind    <= K_PAY;
        end
        default: ;
      endcase

      if (r_state == ST_FETCH) r_cmd <= w_src;
      if (w_usr_accept) r_cmd <= {usr_bank, usr_opcode, usr_addr, usr_data};

      // The bank is known once the final bank-select write has completed
      if (r_state == ST_WAIT_END && drv_end_flag &&
          (r_kind == K_SET || (r_kind == K_CLR && r_cmd.bank == 2'd0))) begin
        r_cur_bank       <= r_cmd.bank;
        r_cur_bank_valid <= 1'b1;
      end
      if (w_timeout) r_cur_bank_valid <= 1'b0;

      if (r_state == ST_GAP && w_gap_done && r_kind == K_PAY && !r_init_done) begin
        if (r_rom_idx == ROM_LAST) r_init_done <= 1'b1;
        else                       r_rom_idx   <= r_rom_idx + 1'b1;
      end
    end
  end

  assign drv_run_req = r_run_req;
  assign drv_opcode  = r_opcode;
  assign drv_addr    = r_addr;
  assign drv_data    = r_data;
  assign usr_ready   = w_usr_ready;
  assign busy        = w_busy;
  assign init_done   = r_init_done;

endmodule
